// File: rtl/mem_port_scheduler_if.sv
// Requester, SRAM and response bundle for mem_port_scheduler.
// The slave side is the scheduler; the master side is its environment.
interface mem_port_scheduler_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic [2:0]      req_valid;
   logic [2:0]      req_ready;
   logic [2:0]      req_we;
   logic [3*AW-1:0] req_addr;
   logic [3*DW-1:0] req_wdata;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [DW-1:0]   rsp_rdata;
   logic            busy;
   logic [1:0]      last_grant;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
      output rsp_valid, rsp_id, rsp_rdata, busy, last_grant
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_rdata,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
      input  rsp_valid, rsp_id, rsp_rdata, busy, last_grant
   );
endinterface

// File: rtl/mem_port_scheduler.sv
// Three-requester round-robin scheduler for a single-port SRAM.
// One transaction in flight; reads wait RD_LAT cycles for data.
module mem_port_scheduler #(
   parameter int AW     = 8,
   parameter int DW     = 16,
   parameter int RD_LAT = 2
) (
   input logic clk,
   input logic reset,
   mem_port_scheduler_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   logic [1:0]    r_state;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [1:0]    r_id;
   logic [1:0]    r_last;
   logic [1:0]    r_cnt;
   logic [1:0]    r_rsp_id;
   logic [DW-1:0] r_rsp_rdata;

   logic [1:0] w_o0, w_o1, w_o2;
   logic [1:0] w_gid;
   logic [2:0] w_grant;
   logic       w_xfer;

   function automatic logic [1:0] nxt(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   assign w_o0 = nxt(r_last);
   assign w_o1 = nxt(w_o0);
   assign w_o2 = nxt(w_o1);

   // Round-robin pick: first valid requester after the last grant.
   always_comb begin
      w_gid   = w_o2;
      w_grant = 3'b000;
      if (bus.req_valid[w_o0])      w_gid = w_o0;
      else if (bus.req_valid[w_o1]) w_gid = w_o1;
      if (r_state == S_IDLE && |bus.req_valid)
         w_grant = 3'b001 << w_gid;
   end

   assign w_xfer = |(bus.req_valid & w_grant);

   assign bus.req_ready  = w_grant;
   assign bus.mem_en     = (r_state == S_ISSUE);
   assign bus.mem_we     = (r_state == S_ISSUE) & r_we;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;
   assign bus.rsp_valid  = (r_state == S_RESP);
   assign bus.rsp_id     = r_rsp_id;
   assign bus.rsp_rdata  = r_rsp_rdata;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.last_grant = r_last;

   // Transaction FSM, request capture and response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_id        <= 2'd0;
         r_last      <= 2'd2;
         r_cnt       <= 2'd0;
         r_rsp_id    <= 2'd0;
         r_rsp_rdata <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_we    <= bus.req_we[w_gid];
                  r_addr  <= bus.req_addr[32'(w_gid)*AW +: AW];
                  r_wdata <= bus.req_wdata[32'(w_gid)*DW +: DW];
                  r_id    <= w_gid;
                  r_last  <= w_gid;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt <= 2'd0;
               if (r_we) begin
                  r_rsp_id    <= r_id;
                  r_rsp_rdata <= '0;
                  r_state     <= S_RESP;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == LAST_CNT) begin
                  r_rsp_id    <= r_id;
                  r_rsp_rdata <= bus.mem_rdata;
                  r_cnt       <= 2'd0;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler (RD_LAT = 2).
// Expected values are hand-derived cycle by cycle.
module tb_mem_port_scheduler;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   mem_port_scheduler_if #(.AW(8), .DW(16)) bus ();

   mem_port_scheduler #(.AW(8), .DW(16), .RD_LAT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.req_valid = 3'b000;
      bus.req_we    = 3'b000;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_rdata = '0;
   endtask

   task automatic chk_reset_state(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_lg"}, 32'(bus.last_grant), 32'd2);
      check({tag, "_men"}, 32'(bus.mem_en), 32'd0);
      check({tag, "_mwe"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_madr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, "_mwd"}, 32'(bus.mem_wdata), 32'd0);
      check({tag, "_rv"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rid"}, 32'(bus.rsp_id), 32'd0);
      check({tag, "_rrd"}, 32'(bus.rsp_rdata), 32'd0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      idle_in();
      reset = 1'b1;
      #1;
      chk_reset_state("rst");
      check("rst_rdy", 32'(bus.req_ready), 32'd0);
      step();
      step();
      reset = 1'b0;

      // Single write from requester 0
      bus.req_valid = 3'b001;
      bus.req_we    = 3'b001;
      bus.req_addr[0 +: 8]   = 8'h10;
      bus.req_wdata[0 +: 16] = 16'hBEEF;
      #1;
      check("wr_rdy", 32'(bus.req_ready), 32'b001);
      step();
      idle_in();
      #1;
      check("wr_men", 32'(bus.mem_en), 32'd1);
      check("wr_mwe", 32'(bus.mem_we), 32'd1);
      check("wr_adr", 32'(bus.mem_addr), 32'h10);
      check("wr_wd", 32'(bus.mem_wdata), 32'hBEEF);
      check("wr_lg", 32'(bus.last_grant), 32'd0);
      check("wr_rv0", 32'(bus.rsp_valid), 32'd0);
      step();
      check("wr_rv", 32'(bus.rsp_valid), 32'd1);
      check("wr_rid", 32'(bus.rsp_id), 32'd0);
      check("wr_rrd", 32'(bus.rsp_rdata), 32'd0);
      check("wr_men2", 32'(bus.mem_en), 32'd0);
      step();
      check("wr_busy", 32'(bus.busy), 32'd0);
      check("wr_rv2", 32'(bus.rsp_valid), 32'd0);
      check("wr_hold", 32'(bus.mem_addr), 32'h10);

      // Single read from requester 1, data returned in T+2
      bus.req_valid = 3'b010;
      bus.req_we    = 3'b000;
      bus.req_addr[8 +: 8] = 8'h10;
      #1;
      check("rd_rdy", 32'(bus.req_ready), 32'b010);
      step();
      idle_in();
      #1;
      check("rd_men", 32'(bus.mem_en), 32'd1);
      check("rd_mwe", 32'(bus.mem_we), 32'd0);
      check("rd_adr", 32'(bus.mem_addr), 32'h10);
      step();
      check("rd_t1_men", 32'(bus.mem_en), 32'd0);
      check("rd_t1_rv", 32'(bus.rsp_valid), 32'd0);
      step();
      bus.mem_rdata = 16'hBEEF;
      check("rd_t2_rv", 32'(bus.rsp_valid), 32'd0);
      step();
      bus.mem_rdata = 16'h0000;
      check("rd_rv", 32'(bus.rsp_valid), 32'd1);
      check("rd_rid", 32'(bus.rsp_id), 32'd1);
      check("rd_rrd", 32'(bus.rsp_rdata), 32'hBEEF);
      step();
      check("rd_busy", 32'(bus.busy), 32'd0);
      check("rd_hold_id", 32'(bus.rsp_id), 32'd1);
      check("rd_hold_rd", 32'(bus.rsp_rdata), 32'hBEEF);

      // Wrap/skip: last_grant=1, requesters 0 and 2 writing
      bus.req_valid = 3'b101;
      bus.req_we    = 3'b101;
      bus.req_addr[16 +: 8] = 8'h22;
      #1;
      check("wrap_rdy2", 32'(bus.req_ready), 32'b100);
      step();
      check("wrap_lg", 32'(bus.last_grant), 32'd2);
      check("wrap_adr", 32'(bus.mem_addr), 32'h22);
      check("wrap_hold", 32'(bus.req_ready), 32'b000);
      step();
      check("wrap_rid", 32'(bus.rsp_id), 32'd2);
      step();
      check("wrap_rdy0", 32'(bus.req_ready), 32'b001);

      // Fairness from reset with all three requesting writes
      reset = 1'b1;
      #1;
      reset = 1'b0;
      bus.req_valid = 3'b111;
      bus.req_we    = 3'b111;
      #1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("fair_rdy%0d", k), 32'(bus.req_ready),
               32'(3'b001 << (k % 3)));
         step();
         step();
         check($sformatf("fair_rid%0d", k), 32'(bus.rsp_id),
               32'(k % 3));
         step();
      end

      // Busy hold-off during a read by requester 0
      idle_in();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      bus.req_valid = 3'b001;
      #1;
      check("ho_rdy0", 32'(bus.req_ready), 32'b001);
      step();
      bus.req_valid = 3'b000;
      step();
      bus.req_valid = 3'b100;
      #1;
      check("ho_wait1", 32'(bus.req_ready), 32'b000);
      step();
      check("ho_wait2", 32'(bus.req_ready), 32'b000);
      step();
      check("ho_resp", 32'(bus.req_ready), 32'b000);
      check("ho_rv", 32'(bus.rsp_valid), 32'd1);
      step();
      check("ho_idle", 32'(bus.req_ready), 32'b100);

      // Reset in WAIT of requester 2's read
      step();
      bus.req_valid = 3'b000;
      step();
      check("mr_busy_pre", 32'(bus.busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_state("mr");
      step();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mr_men%0d", k), 32'(bus.mem_en), 32'd0);
         check($sformatf("mr_rv%0d", k), 32'(bus.rsp_valid), 32'd0);
         step();
      end
      bus.req_valid = 3'b111;
      #1;
      check("mr_next", 32'(bus.req_ready), 32'b001);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 Parameter AW, default 8: address width.
REQ-002 Parameter DW, default 16: data width.
REQ-003 Parameter RD_LAT, default 2, legal 1..3: SRAM read latency in cycles.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  3  per-requester access request; bit i = requester i.
REQ-007 req_ready  output  3  one-hot accept; transfer on requester i when req_valid[i] & req_ready[i].
REQ-008 req_we  input  3  per-requester write enable (1 = write, 0 = read).
REQ-009 req_addr  input  3*AW  requester i address in bits [i*AW +: AW].
REQ-010 req_wdata  input  3*DW  requester i write data in bits [i*DW +: DW].
REQ-011 mem_en  output  1  SRAM access strobe, one cycle per transaction.
REQ-012 mem_we  output  1  SRAM write enable, valid with mem_en.
REQ-013 mem_addr  output  AW  SRAM address, valid with mem_en.
REQ-014 mem_wdata  output  DW  SRAM write data, valid with mem_en.
REQ-015 mem_rdata  input  DW  SRAM read data, valid RD_LAT cycles after mem_en cycle.
REQ-016 rsp_valid  output  1  one-cycle completion pulse.
REQ-017 rsp_id  output  2  requester index of completing transaction (0..2).
REQ-018 rsp_rdata  output  DW  read data with rsp_valid; 0 for writes.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 last_grant  output  2  index of most recently accepted requester.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-022 req_ready SHALL be combinational, nonzero only in IDLE, one-hot on the arbitration winner among req_valid, zero when req_valid == 0.
REQ-023 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod 3 and wraps (e.g. last_grant=1 -> order 2,0,1).
REQ-024 On transfer, winner's we/addr/wdata and index SHALL be registered, last_grant updated, state -> ISSUE.
REQ-025 ISSUE (cycle T) SHALL drive mem_en=1 with registered we/addr/wdata; mem_en, mem_we SHALL be 0 in all other states; mem_addr/mem_wdata hold last values.
REQ-026 Write: ISSUE -> RESP; rsp_valid=1 in T+1, rsp_rdata=0.
REQ-027 Read: ISSUE -> WAIT; 2-bit counter counts RD_LAT cycles; mem_rdata sampled at end of cycle T+RD_LAT; RESP in T+RD_LAT+1 with rsp_rdata = sampled value.
REQ-028 RESP SHALL last exactly one cycle, rsp_valid=1, rsp_id=registered index, then -> IDLE; rsp_valid=0 in all other states.
REQ-029 Requests arriving while busy SHALL be held off (req_ready=0); a requester may drop req_valid before acceptance with no side effects.
REQ-030 Per-transaction occupancy: write 3 cycles (IDLE accept, ISSUE, RESP); read RD_LAT+3 cycles.
REQ-031 rsp_id and rsp_rdata SHALL hold values between responses.

Reset
REQ-032 On reset: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, busy=0, last_grant=2 (requester 0 first priority), wait counter=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no response; no mem_en after reset deasserts until a new transfer.

Verification
REQ-034 Single write: req_valid=001, we=1, addr=0x10, wdata=0xBEEF -> req_ready=001 same cycle, mem_en/mem_we=1 with 0x10/0xBEEF next cycle, rsp_valid id=0 rdata=0 one cycle later.
REQ-035 Single read RD_LAT=2: requester 1 reads 0x10, SRAM returns 0xBEEF in T+2 -> rsp_valid in T+3, rsp_id=1, rsp_rdata=0xBEEF, busy low after.
REQ-036 Fairness: req_valid=111 held continuously from reset -> accept order 0,1,2,0,1,2; no requester waits more than two transactions.
REQ-037 Wrap/skip: last_grant=1, req_valid=101 -> requester 2 granted; then last_grant=2 -> requester 0 granted.
REQ-038 Busy hold-off: requester 2 asserts req_valid during WAIT of requester 0's read -> req_ready stays 000 until IDLE, then 100.
REQ-039 Reset mid-read in WAIT -> all outputs to REQ-032 values immediately, no rsp_valid, next grant goes to requester 0.
